// File: rtl/layer_pass_scheduler.sv
// Layer-level tile-loop sequencer: walks row/oc/ic tiles, one pass_start per tile.
// Optional pass watchdog enabled by defining PASS_TIMEOUT_EN.
module layer_pass_scheduler #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             layer_start_i,
    input  logic [1:0]       layer_type_i,
    input  logic [CNT_W-1:0] num_row_tile_i,
    input  logic [CNT_W-1:0] num_oc_tile_i,
    input  logic [CNT_W-1:0] num_ic_tile_i,
    input  logic             pass_done_i,
    output logic             pass_start_o,
    output logic [CNT_W-1:0] row_idx_o,
    output logic [CNT_W-1:0] oc_idx_o,
    output logic [CNT_W-1:0] ic_idx_o,
    output logic             first_ic_o,
    output logic             last_ic_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic             busy_o,
    output logic             layer_done_o
`ifdef PASS_TIMEOUT_EN
    ,
    output logic             timeout_err_o
`endif
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, DONE} state_e;
    typedef enum logic [1:0] {POINTWISE, DEPTHWISE, STANDARD, LINEAR} layer_type_e;

    state_e           state_q, state_d;
    layer_type_e      type_q;
    logic [CNT_W-1:0] row_cnt_q, oc_cnt_q, ic_cnt_q, ic_eff;
    logic [CNT_W-1:0] row_q, oc_q, ic_q, pass_cnt_q;
    logic             start_ok, row_last, oc_last, ic_last, any_zero, timeout;

    assign ic_eff   = (type_q == DEPTHWISE) ? CNT_W'(1) : ic_cnt_q;
    assign ic_last  = (ic_q  == ic_eff    - CNT_W'(1));
    assign oc_last  = (oc_q  == oc_cnt_q  - CNT_W'(1));
    assign row_last = (row_q == row_cnt_q - CNT_W'(1));
    assign any_zero = (row_cnt_q == '0) || (oc_cnt_q == '0) || (ic_eff == '0);
    assign start_ok = (state_q == IDLE) && layer_start_i;

`ifdef PASS_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        err_q;

    assign timeout       = (state_q == WAIT) && !pass_done_i && (wd_q >= TIMEOUT_CYC - 32'd1);
    assign timeout_err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)
                wd_q <= '0;
            else if (state_q == WAIT)
                wd_q <= wd_q + 32'd1;
            if (start_ok)
                err_q <= 1'b0;
            else if (timeout)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // The zero-count check uses the latched counts, so an empty layer
    // passes through ISSUE (with pass_start suppressed) before DONE.
    always_comb begin
        state_d      = state_q;
        pass_start_o = 1'b0;
        layer_done_o = 1'b0;
        case (state_q)
            IDLE:    if (layer_start_i) state_d = ISSUE;
            ISSUE: begin
                pass_start_o = !any_zero;
                state_d      = any_zero ? DONE : WAIT;
            end
            WAIT: begin
                if (pass_done_i)  state_d = ADVANCE;
                else if (timeout) state_d = DONE;
            end
            ADVANCE: state_d = (row_last && oc_last && ic_last) ? DONE : ISSUE;
            DONE: begin
                layer_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q     <= POINTWISE;
            row_cnt_q  <= '0;
            oc_cnt_q   <= '0;
            ic_cnt_q   <= '0;
            row_q      <= '0;
            oc_q       <= '0;
            ic_q       <= '0;
            pass_cnt_q <= '0;
        end else begin
            if (start_ok) begin
                type_q     <= layer_type_e'(layer_type_i);
                row_cnt_q  <= num_row_tile_i;
                oc_cnt_q   <= num_oc_tile_i;
                ic_cnt_q   <= num_ic_tile_i;
                row_q      <= '0;
                oc_q       <= '0;
                ic_q       <= '0;
                pass_cnt_q <= '0;
            end
            if (state_q == WAIT && pass_done_i)
                pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            if (state_q == ADVANCE) begin
                if (!ic_last) begin
                    ic_q <= ic_q + CNT_W'(1);
                end else begin
                    ic_q <= '0;
                    if (!oc_last) begin
                        oc_q <= oc_q + CNT_W'(1);
                    end else begin
                        oc_q  <= '0;
                        row_q <= row_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign first_ic_o = busy_o && (ic_q == '0);
    assign last_ic_o  = busy_o && ic_last;
    assign row_idx_o  = row_q;
    assign oc_idx_o   = oc_q;
    assign ic_idx_o   = ic_q;
    assign pass_cnt_o = pass_cnt_q;

endmodule

// File: tb/tb_layer_pass_scheduler.sv
// Self-checking bench for layer_pass_scheduler: table cases, randomized layers,
// mid-layer reset and (with PASS_TIMEOUT_EN) the pass watchdog.
module tb_layer_pass_scheduler;

    localparam int W  = 16;
    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         layer_start_i;
    logic [1:0]   layer_type_i;
    logic [W-1:0] num_row_tile_i, num_oc_tile_i, num_ic_tile_i;
    logic         pass_done_i;
    logic         pass_start_o, first_ic_o, last_ic_o, busy_o, layer_done_o;
    logic [W-1:0] row_idx_o, oc_idx_o, ic_idx_o, pass_cnt_o;
`ifdef PASS_TIMEOUT_EN
    logic         timeout_err_o;
`endif

    always #5 clk = ~clk;

    layer_pass_scheduler #(.CNT_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .layer_start_i  (layer_start_i),
        .layer_type_i   (layer_type_i),
        .num_row_tile_i (num_row_tile_i),
        .num_oc_tile_i  (num_oc_tile_i),
        .num_ic_tile_i  (num_ic_tile_i),
        .pass_done_i    (pass_done_i),
        .pass_start_o   (pass_start_o),
        .row_idx_o      (row_idx_o),
        .oc_idx_o       (oc_idx_o),
        .ic_idx_o       (ic_idx_o),
        .first_ic_o     (first_ic_o),
        .last_ic_o      (last_ic_o),
        .pass_cnt_o     (pass_cnt_o),
        .busy_o         (busy_o),
        .layer_done_o   (layer_done_o)
`ifdef PASS_TIMEOUT_EN
        ,
        .timeout_err_o  (timeout_err_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ty;
        int r;
        int o;
        int i;
        int dly;
        bit noise;
        int exp_passes;
    } layer_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble;
        layer_type_i   = 2'($urandom);
        num_row_tile_i = W'($urandom);
        num_oc_tile_i  = W'($urandom);
        num_ic_tile_i  = W'($urandom);
    endtask

    // Reference: expected tile order from plain nested loops over the layer shape.
    task automatic run_layer(input layer_t L, input int abort_k);
        int qr[$], qo[$], qi[$];
        int ieff;
        ieff = (L.ty == 1) ? 1 : L.i;
        for (int r = 0; r < L.r; r++)
            for (int o = 0; o < L.o; o++)
                for (int i = 0; i < ieff; i++) begin
                    qr.push_back(r); qo.push_back(o); qi.push_back(i);
                end

        tick;
        chk("idle_busy", busy_o, 0);
        chk("idle_done", layer_done_o, 0);
        layer_start_i  = 1'b1;
        layer_type_i   = 2'(L.ty);
        num_row_tile_i = W'(L.r);
        num_oc_tile_i  = W'(L.o);
        num_ic_tile_i  = W'(L.i);
        tick;
        layer_start_i = 1'b0;
        scramble();

        if (qr.size() == 0) begin
            chk("zero_nostart", pass_start_o, 0);
            chk("zero_early_done", layer_done_o, 0);
            tick;
            chk("zero_done", layer_done_o, 1);
            chk("zero_nostart2", pass_start_o, 0);
            chk("zero_cnt", pass_cnt_o, 0);
            return;
        end

        for (int k = 0; k < qr.size(); k++) begin
            chk("pstart", pass_start_o, 1);
            chk("no_done_mid", layer_done_o, 0);
            chk("row_idx", row_idx_o, qr[k]);
            chk("oc_idx", oc_idx_o, qo[k]);
            chk("ic_idx", ic_idx_o, qi[k]);
            chk("first_ic", first_ic_o, (qi[k] == 0) ? 1 : 0);
            chk("last_ic", last_ic_o, (qi[k] == ieff - 1) ? 1 : 0);
            chk("busy", busy_o, 1);
            if (L.noise) layer_start_i = 1'b1;
            for (int d = 1; d < L.dly; d++) begin
                tick;
                layer_start_i = 1'b0;
                chk("wait_nostart", pass_start_o, 0);
                chk("wait_ic_stable", ic_idx_o, qi[k]);
                if (abort_k == k) begin
                    rst = 1'b1;
                    #1;
                    chk("arst_busy", busy_o, 0);
                    chk("arst_pstart", pass_start_o, 0);
                    chk("arst_done", layer_done_o, 0);
                    chk("arst_cnt", pass_cnt_o, 0);
                    chk("arst_idx", {row_idx_o, oc_idx_o} | 32'(ic_idx_o), 0);
                    chk("arst_flags", {first_ic_o, last_ic_o}, 0);
                    tick;
                    rst = 1'b0;
                    chk("arst_idle", busy_o, 0);
                    return;
                end
            end
            tick;
            layer_start_i = 1'b0;
            pass_done_i   = 1'b1;
            chk("done_cyc_nostart", pass_start_o, 0);
            tick;
            pass_done_i = L.noise;
            chk("pass_cnt", pass_cnt_o, k + 1);
            chk("adv_nostart", pass_start_o, 0);
            tick;
            pass_done_i = 1'b0;
        end
        chk("layer_done", layer_done_o, 1);
        chk("final_cnt", pass_cnt_o, L.exp_passes);
        chk("final_nostart", pass_start_o, 0);
    endtask

    layer_t tbl[7];
    layer_t rl;

    initial begin
        tbl[0] = '{ty: 2, r: 2, o: 2, i: 3, dly: 5, noise: 1'b0, exp_passes: 12};
        tbl[1] = '{ty: 1, r: 3, o: 2, i: 7, dly: 3, noise: 1'b0, exp_passes: 6};
        tbl[2] = '{ty: 0, r: 1, o: 1, i: 1, dly: 1, noise: 1'b0, exp_passes: 1};
        tbl[3] = '{ty: 0, r: 1, o: 1, i: 1, dly: 1, noise: 1'b0, exp_passes: 1};
        tbl[4] = '{ty: 2, r: 2, o: 0, i: 3, dly: 2, noise: 1'b0, exp_passes: 0};
        tbl[5] = '{ty: 3, r: 1, o: 3, i: 2, dly: 2, noise: 1'b1, exp_passes: 6};
        tbl[6] = '{ty: 0, r: 2, o: 2, i: 2, dly: 1, noise: 1'b1, exp_passes: 8};

        rst = 1'b1;
        layer_start_i = 1'b0;
        pass_done_i   = 1'b0;
        layer_type_i  = '0;
        num_row_tile_i = '0;
        num_oc_tile_i  = '0;
        num_ic_tile_i  = '0;
        tick;
        tick;
        chk("rst_busy", busy_o, 0);
        chk("rst_pstart", pass_start_o, 0);
        chk("rst_done", layer_done_o, 0);
        chk("rst_cnt", pass_cnt_o, 0);
        chk("rst_idx", {row_idx_o, oc_idx_o} | 32'(ic_idx_o), 0);
`ifdef PASS_TIMEOUT_EN
        chk("rst_terr", timeout_err_o, 0);
`endif
        rst = 1'b0;

        for (int n = 0; n < 7; n++) run_layer(tbl[n], -1);

        // Reset while waiting on pass 4 of 12, then a full clean layer.
        run_layer(tbl[0], 3);
        run_layer(tbl[0], -1);

        for (int n = 0; n < 12; n++) begin
            rl.ty    = int'($urandom_range(0, 3));
            rl.r     = int'($urandom_range(1, 3));
            rl.o     = int'($urandom_range(0, 3));
            rl.i     = int'($urandom_range(1, 4));
            rl.dly   = int'($urandom_range(1, 4));
            rl.noise = 1'($urandom_range(0, 1));
            rl.exp_passes = rl.r * rl.o * ((rl.ty == 1) ? 1 : rl.i);
            run_layer(rl, -1);
        end

`ifdef PASS_TIMEOUT_EN
        begin
            bit seen;
            seen = 1'b0;
            tick;
            layer_start_i  = 1'b1;
            layer_type_i   = 2'd2;
            num_row_tile_i = W'(2);
            num_oc_tile_i  = W'(2);
            num_ic_tile_i  = W'(3);
            tick;
            layer_start_i = 1'b0;
            chk("to_pstart1", pass_start_o, 1);
            tick;
            pass_done_i = 1'b1;
            tick;
            pass_done_i = 1'b0;
            tick;
            chk("to_pstart2", pass_start_o, 1);
            for (int c = 0; c < 100 && !seen; c++) begin
                tick;
                if (layer_done_o) seen = 1'b1;
            end
            chk("to_layer_done", seen, 1);
            chk("to_err", timeout_err_o, 1);
            chk("to_cnt", pass_cnt_o, 1);
            tick;
            chk("to_sticky", timeout_err_o, 1);
            chk("to_idle", busy_o, 0);
            run_layer(tbl[2], -1);
            chk("to_cleared", timeout_err_o, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
